// File: rtl/instruction_fetch_unit_if.sv
// Instruction-cache read bus between the fetch unit (master) and the cache (slave).
// The cache answers imem_read combinationally on imem_busywait and imem_readdata.
interface instruction_fetch_unit_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_readdata;
    logic        imem_busywait;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_readdata,
        input  imem_busywait
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_readdata,
        output imem_busywait
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues instruction-cache reads, feeds the IF/ID register.
// state    | meaning
// FETCH    | request open at pc_reg; cache data passed straight through
// HOLD     | word fetched during a stall, replayed from buffer until stall drops
// REDIRECT | branch arrived mid-miss; finish the old request, then jump to pending
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            branch_jump_signal,
    input  logic [31:0]                     branch_target,
    instruction_fetch_unit_if.master        imem,
    output logic [31:0]                     pc_out,
    output logic [31:0]                     pc_4_out,
    output logic [31:0]                     instruction_out,
    output logic                            fetch_busywait,
    output logic                            fetch_error
);

    typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} state_t;

    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);

    state_t      state, state_n;
    logic [31:0] pc_reg, pc_n;
    logic [31:0] pending, pending_n;
    logic [31:0] buffer, buffer_n;
    logic        buf_valid, buf_valid_n;
    logic [15:0] timeout_cnt, timeout_cnt_n;
    logic        fetch_error_n;
    logic [31:0] target;
    logic        completion;
    logic        busy_cycle;
    logic        redirect_to_fetch;

    assign target     = {branch_target[31:2], 2'b00};
    assign pc_out     = pc_reg;
    assign pc_4_out   = pc_reg + 32'd4;
    assign completion = imem.imem_read & ~imem.imem_busywait;
    assign busy_cycle = imem.imem_read & imem.imem_busywait;

    always_comb begin
        imem.imem_read    = 1'b0;
        imem.imem_address = pc_reg;
        instruction_out   = '0;
        fetch_busywait    = 1'b1;
        case (state)
            FETCH: begin
                imem.imem_read  = ~reset;
                instruction_out = imem.imem_readdata;
                fetch_busywait  = imem.imem_busywait;
            end
            HOLD: begin
                instruction_out = buffer;
                fetch_busywait  = ~buf_valid;
            end
            REDIRECT: begin
                imem.imem_read = ~reset;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n           = state;
        pc_n              = pc_reg;
        pending_n         = pending;
        buffer_n          = buffer;
        buf_valid_n       = buf_valid;
        redirect_to_fetch = 1'b0;
        if (branch_jump_signal) begin
            if (state == FETCH && imem.imem_busywait) begin
                pending_n = target;
                state_n   = REDIRECT;
            end else if (state == REDIRECT && !completion) begin
                pending_n = target;
            end else begin
                // Includes REDIRECT finishing this cycle: the newest target wins outright.
                pc_n              = target;
                buf_valid_n       = 1'b0;
                state_n           = FETCH;
                redirect_to_fetch = 1'b1;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (completion && !stall) begin
                        pc_n = pc_reg + 32'd4;
                    end else if (completion) begin
                        buffer_n    = imem.imem_readdata;
                        buf_valid_n = 1'b1;
                        state_n     = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_n        = pc_reg + 32'd4;
                        buf_valid_n = 1'b0;
                        state_n     = FETCH;
                    end
                end
                REDIRECT: begin
                    if (completion) begin
                        pc_n    = pending;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_comb begin
        timeout_cnt_n = timeout_cnt;
        if (completion || redirect_to_fetch) begin
            timeout_cnt_n = '0;
        end else if (busy_cycle && timeout_cnt != TIMEOUT_MAX) begin
            timeout_cnt_n = timeout_cnt + 16'd1;
        end
        fetch_error_n = fetch_error | (timeout_cnt_n == TIMEOUT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc_reg      <= RESET_PC;
            pending     <= RESET_PC;
            buffer      <= '0;
            buf_valid   <= 1'b0;
            timeout_cnt <= '0;
            fetch_error <= 1'b0;
        end else begin
            state       <= state_n;
            pc_reg      <= pc_n;
            pending     <= pending_n;
            buffer      <= buffer_n;
            buf_valid   <= buf_valid_n;
            timeout_cnt <= timeout_cnt_n;
            fetch_error <= fetch_error_n;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a scripted cache responder plus a queue of
// expected (pc, word) pairs popped whenever the IF/ID register would sample.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned TIMEOUT  = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_jump_signal = 1'b0;
    logic [31:0] branch_target = '0;
    logic        busy = 1'b0;
    logic [31:0] pc_out, pc_4_out, instruction_out;
    logic        fetch_busywait, fetch_error;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t exp_q[$];

    instruction_fetch_unit_if imem ();

    assign imem.imem_busywait = imem.imem_read & busy;
    assign imem.imem_readdata = mem_word(imem.imem_address);

    instruction_fetch_unit #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .branch_jump_signal (branch_jump_signal),
        .branch_target      (branch_target),
        .imem               (imem),
        .pc_out             (pc_out),
        .pc_4_out           (pc_4_out),
        .instruction_out    (instruction_out),
        .fetch_busywait     (fetch_busywait),
        .fetch_error        (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    // Leaves reset released just after a posedge, so the next negedge sees pc=RESET_PC.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; stall = 1'b0; branch_jump_signal = 1'b0; busy = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; busy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (imem.imem_read !== 1'b0) begin
            tests_failed++; $display("FAIL reset_read: got %b expected 0", imem.imem_read);
        end
        tests_run++;
        if (pc_out !== RESET_PC || pc_4_out !== RESET_PC + 32'd4) begin
            tests_failed++; $display("FAIL reset_pc: got %h/%h expected %h/%h", pc_out, pc_4_out, RESET_PC, RESET_PC + 32'd4);
        end
        tests_run++;
        if (fetch_error !== 1'b0) begin
            tests_failed++; $display("FAIL reset_error: got %b expected 0", fetch_error);
        end
        busy = 1'b0;
    endtask

    task automatic test_hit_sequence();
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            tests_run++;
            if (fetch_busywait !== 1'b0) begin
                tests_failed++; $display("FAIL hit_busywait c%0d: got %b expected 0", c, fetch_busywait);
            end
            if (!reset && !stall && !fetch_busywait) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL hit_extra: unexpected pc %h", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_4_out !== e.pc + 32'd4 || instruction_out !== e.instr) begin
                        tests_failed++; $display("FAIL hit_sb: got pc %h word %h expected pc %h word %h", pc_out, instruction_out, e.pc, e.instr);
                    end
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL hit_left: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_miss();
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            busy = (c >= 2 && c <= 4);
            #1;
            if (busy) begin
                tests_run++;
                if (fetch_busywait !== 1'b1 || imem.imem_address !== 32'h8) begin
                    tests_failed++; $display("FAIL miss_wait c%0d: got busy %b addr %h expected 1 and 8", c, fetch_busywait, imem.imem_address);
                end
            end
            if (!reset && !stall && !fetch_busywait) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL miss_extra: unexpected pc %h", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_4_out !== e.pc + 32'd4 || instruction_out !== e.instr) begin
                        tests_failed++; $display("FAIL miss_sb c%0d: got pc %h word %h expected pc %h word %h", c, pc_out, instruction_out, e.pc, e.instr);
                    end
                end
            end
        end
        busy = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL miss_left: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall_hold();
        exp_t e;
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            stall = (c == 4 || c == 5);
            #1;
            if (c == 5 || c == 6) begin
                tests_run++;
                if (imem.imem_read !== 1'b0 || pc_out !== 32'h10 || instruction_out !== mem_word(32'h10) || fetch_busywait !== 1'b0) begin
                    tests_failed++; $display("FAIL hold c%0d: got read %b pc %h word %h busy %b expected 0 10 %h 0", c, imem.imem_read, pc_out, instruction_out, fetch_busywait, mem_word(32'h10));
                end
            end
            if (!reset && !stall && !fetch_busywait) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL hold_extra: unexpected pc %h", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_4_out !== e.pc + 32'd4 || instruction_out !== e.instr) begin
                        tests_failed++; $display("FAIL hold_sb c%0d: got pc %h word %h expected pc %h word %h", c, pc_out, instruction_out, e.pc, e.instr);
                    end
                end
            end
        end
        stall = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL hold_left: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        do_reset();
        push_exp(32'h0); push_exp(32'h100); push_exp(32'h200);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            branch_jump_signal = 1'b0; busy = 1'b0;
            case (c)
                0: begin branch_jump_signal = 1'b1; branch_target = 32'h40; end
                1: begin busy = 1'b1; branch_jump_signal = 1'b1; branch_target = 32'h103; end
                2, 3, 5: busy = 1'b1;
                7: begin busy = 1'b1; branch_jump_signal = 1'b1; branch_target = 32'h180; end
                8: begin busy = 1'b1; branch_jump_signal = 1'b1; branch_target = 32'h200; end
                default: ;
            endcase
            #1;
            if (c >= 2 && c <= 4) begin
                tests_run++;
                if (imem.imem_address !== 32'h40 || fetch_busywait !== 1'b1 || instruction_out !== 32'h0) begin
                    tests_failed++; $display("FAIL redir_inflight c%0d: got addr %h busy %b word %h expected 40 1 0", c, imem.imem_address, fetch_busywait, instruction_out);
                end
            end
            if (c == 5) begin
                tests_run++;
                if (imem.imem_address !== 32'h100 || fetch_busywait !== 1'b1) begin
                    tests_failed++; $display("FAIL redir_target: got addr %h busy %b expected 100 1", imem.imem_address, fetch_busywait);
                end
            end
            if (c == 9) begin
                tests_run++;
                if (imem.imem_address !== 32'h104 || fetch_busywait !== 1'b1) begin
                    tests_failed++; $display("FAIL redir_second: got addr %h busy %b expected 104 1", imem.imem_address, fetch_busywait);
                end
            end
            if (!reset && !stall && !fetch_busywait) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL redir_extra: unexpected pc %h", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_4_out !== e.pc + 32'd4 || instruction_out !== e.instr) begin
                        tests_failed++; $display("FAIL redir_sb c%0d: got pc %h word %h expected pc %h word %h", c, pc_out, instruction_out, e.pc, e.instr);
                    end
                end
            end
        end
        branch_jump_signal = 1'b0; busy = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL redir_left: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_branch_over_stall();
        exp_t e;
        do_reset();
        push_exp(32'h80);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            stall = (c == 0); branch_jump_signal = (c == 0); branch_target = 32'h80;
            #1;
            if (c == 1) begin
                tests_run++;
                if (pc_out !== 32'h80 || imem.imem_read !== 1'b1) begin
                    tests_failed++; $display("FAIL br_stall: got pc %h read %b expected 80 1", pc_out, imem.imem_read);
                end
            end
            if (!reset && !stall && !fetch_busywait) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL br_stall_extra: unexpected pc %h", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_4_out !== e.pc + 32'd4 || instruction_out !== e.instr) begin
                        tests_failed++; $display("FAIL br_stall_sb: got pc %h word %h expected pc %h word %h", pc_out, instruction_out, e.pc, e.instr);
                    end
                end
            end
        end
        stall = 1'b0; branch_jump_signal = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL br_stall_left: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset();
        push_exp(32'h0); push_exp(32'hFFFF_FFFC); push_exp(32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            branch_jump_signal = (c == 0); branch_target = 32'hFFFF_FFFF;
            #1;
            if (c == 1) begin
                tests_run++;
                if (pc_4_out !== 32'h0) begin
                    tests_failed++; $display("FAIL wrap_pc4: got %h expected 0", pc_4_out);
                end
            end
            if (!reset && !stall && !fetch_busywait) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL wrap_extra: unexpected pc %h", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_4_out !== e.pc + 32'd4 || instruction_out !== e.instr) begin
                        tests_failed++; $display("FAIL wrap_sb c%0d: got pc %h word %h expected pc %h word %h", c, pc_out, instruction_out, e.pc, e.instr);
                    end
                end
            end
        end
        branch_jump_signal = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL wrap_left: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        do_reset();
        push_exp(RESET_PC); push_exp(RESET_PC);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            busy  = (c <= 3 || c == 5 || c == 6);
            reset = (c == 6);
            #1;
            if (c <= 3) begin
                tests_run++;
                if (fetch_error !== 1'b0) begin
                    tests_failed++; $display("FAIL timeout_early c%0d: got %b expected 0", c, fetch_error);
                end
            end
            if (c == 4 || c == 5) begin
                tests_run++;
                if (fetch_error !== 1'b1) begin
                    tests_failed++; $display("FAIL timeout_set c%0d: got %b expected 1", c, fetch_error);
                end
            end
            if (c == 5) begin
                tests_run++;
                if (pc_out !== RESET_PC + 32'd4) begin
                    tests_failed++; $display("FAIL timeout_adv: got pc %h expected %h", pc_out, RESET_PC + 32'd4);
                end
            end
            if (c == 6) begin
                tests_run++;
                if (imem.imem_read !== 1'b0) begin
                    tests_failed++; $display("FAIL reset_midmiss_read: got %b expected 0", imem.imem_read);
                end
            end
            if (c == 7) begin
                tests_run++;
                if (pc_out !== RESET_PC || fetch_error !== 1'b0 || imem.imem_read !== 1'b1) begin
                    tests_failed++; $display("FAIL reset_midmiss_after: got pc %h err %b read %b expected %h 0 1", pc_out, fetch_error, imem.imem_read, RESET_PC);
                end
            end
            if (!reset && !stall && !fetch_busywait) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++; $display("FAIL timeout_extra: unexpected pc %h", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    if (pc_out !== e.pc || pc_4_out !== e.pc + 32'd4 || instruction_out !== e.instr) begin
                        tests_failed++; $display("FAIL timeout_sb c%0d: got pc %h word %h expected pc %h word %h", c, pc_out, instruction_out, e.pc, e.instr);
                    end
                end
            end
        end
        busy = 1'b0; reset = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL timeout_left: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_hit_sequence();
        test_miss();
        test_stall_hold();
        test_redirect();
        test_branch_over_stall();
        test_wrap();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
